// File: rtl/adc_pkg.sv
// Shared types and sizes for the LTC2308 channel scan sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package adc_pkg;

    localparam int NCH = 8;
    localparam int DW  = 12;
    localparam int CW  = $clog2(NCH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One stage of the two-frame ADC pipeline: which channel a frame configured.
    typedef struct packed {
        logic          v;
        logic [CW-1:0] ch;
    } tag_t;

endpackage

// File: rtl/adc_next_chan.sv
// Priority search over a channel mask: next enabled channel above cur, and lowest enabled.
// Latency: combinational.
// Backpressure: none.
module adc_next_chan
    import adc_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  logic [CW-1:0]  cur,
    output logic           found,
    output logic [CW-1:0]  nxt_ch,
    output logic [CW-1:0]  first_ch
);

    // Scan from the top down so the last hit is the lowest qualifying channel.
    always_comb begin
        found    = 1'b0;
        nxt_ch   = '0;
        first_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_ch = CW'(i);
                if (CW'(i) > cur) begin
                    found  = 1'b1;
                    nxt_ch = CW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Steps the LTC2308 channel select over an enable mask and files returned samples per channel.
// Latency: sample of the channel issued at frame edge k lands in the bank one clk after edge k+2.
// Backpressure: none; starts while busy are dropped, stop drains the pass in flight.
module adc_scan_sequencer
    import adc_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] enable_mask,
    input  logic           start,
    input  logic           continuous,
    input  logic           stop,
    input  logic           adc_convst,
    input  logic [DW-1:0]  adc_result,
    output logic [CW-1:0]  chan,
    output logic           busy,
    output logic           scan_done,
    output logic [NCH-1:0] ch_valid,
    input  logic [CW-1:0]  rd_chan,
    output logic [DW-1:0]  rd_data
);

    state_t         state_q, state_d;
    tag_t           tag0_q, tag0_d, tag1_q, tag1_d;
    // Marks a tag as the pass-end (highest enabled) channel so scan_done survives a mask wrap.
    logic           last0_q, last0_d, last1_q, last1_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic           cont_q, cont_d;
    logic           stop_q, stop_d;
    logic [CW-1:0]  chan_q, chan_d;
    logic [NCH-1:0] ch_valid_q, ch_valid_d;
    logic           scan_done_q, scan_done_d;
    logic           convst_q;
    logic [DW-1:0]  bank_q [NCH];

    logic           frame_edge;
    logic           issuing;
    logic           stop_seen;
    logic           bank_we;
    logic [CW-1:0]  bank_wa;

    logic           step_found;
    logic [CW-1:0]  step_ch;
    logic [CW-1:0]  wrap_first;
    logic [CW-1:0]  unused_step_first;
    logic           unused_wrap_found;
    logic [CW-1:0]  unused_wrap_nxt;

    // Step within the latched pass mask.
    adc_next_chan u_step (
        .mask     (mask_q),
        .cur      (chan_q),
        .found    (step_found),
        .nxt_ch   (step_ch),
        .first_ch (unused_step_first)
    );

    // Lowest channel of the live mask, used at start and at the continuous wrap.
    adc_next_chan u_wrap (
        .mask     (enable_mask),
        .cur      (chan_q),
        .found    (unused_wrap_found),
        .nxt_ch   (unused_wrap_nxt),
        .first_ch (wrap_first)
    );

    assign frame_edge = adc_convst & ~convst_q;
    assign issuing    = (state_q == SCAN);
    assign stop_seen  = stop_q | stop;

    // Pipeline shift on each frame edge, then scan control; a start overrides the valid clear.
    always_comb begin
        state_d     = state_q;
        tag0_d      = tag0_q;
        tag1_d      = tag1_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        mask_d      = mask_q;
        cont_d      = cont_q;
        stop_d      = stop_q;
        chan_d      = chan_q;
        ch_valid_d  = ch_valid_q;
        scan_done_d = 1'b0;
        bank_we     = 1'b0;
        bank_wa     = tag1_q.ch;

        if (frame_edge) begin
            if (tag1_q.v) begin
                bank_we                = 1'b1;
                ch_valid_d[tag1_q.ch]  = 1'b1;
                scan_done_d            = last1_q;
            end
            tag1_d    = tag0_q;
            last1_d   = last0_q;
            tag0_d.v  = issuing;
            tag0_d.ch = chan_q;
            last0_d   = issuing & ~step_found;
        end

        case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (start && (|enable_mask)) begin
                    mask_d     = enable_mask;
                    cont_d     = continuous;
                    ch_valid_d = '0;
                    chan_d     = wrap_first;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (frame_edge) begin
                    if (step_found) begin
                        chan_d = step_ch;
                    end else if (cont_q && !stop_seen && (|enable_mask)) begin
                        chan_d = wrap_first;
                        mask_d = enable_mask;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!tag0_d.v && !tag1_d.v) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and pipeline state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tag0_q      <= '0;
            tag1_q      <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            mask_q      <= '0;
            cont_q      <= 1'b0;
            stop_q      <= 1'b0;
            chan_q      <= '0;
            ch_valid_q  <= '0;
            scan_done_q <= 1'b0;
            convst_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
            mask_q      <= mask_d;
            cont_q      <= cont_d;
            stop_q      <= stop_d;
            chan_q      <= chan_d;
            ch_valid_q  <= ch_valid_d;
            scan_done_q <= scan_done_d;
            convst_q    <= adc_convst;
        end
    end

    // Per-channel result bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bank_we) begin
            bank_q[bank_wa] <= adc_result;
        end
    end

    assign chan      = chan_q;
    assign busy      = (state_q != IDLE);
    assign scan_done = scan_done_q;
    assign ch_valid  = ch_valid_q;
    assign rd_data   = bank_q[rd_chan];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench: ADC frame model plus scoreboard of expected issued channels and bank contents.
// Latency: model returns each config's sample two frame edges after it is captured.
// Backpressure: not applicable; frames are driven back to back at a fixed length.
module tb_adc_scan_sequencer;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  enable_mask;
    logic        start;
    logic        continuous;
    logic        stop;
    logic        adc_convst;
    logic [11:0] adc_result;
    logic [2:0]  chan;
    logic        busy;
    logic        scan_done;
    logic [7:0]  ch_valid;
    logic [2:0]  rd_chan;
    logic [11:0] rd_data;

    int n_vec  = 0;
    int n_err  = 0;
    int sd_cnt = 0;
    int sd0;

    logic [2:0]  exp_q [$];
    logic [11:0] m_bank [8];
    logic [2:0]  cfg1, cfg2;
    logic [11:0] res1, res2;
    bit          iss1, iss2;
    bit          rnd;

    adc_scan_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enable_mask (enable_mask),
        .start       (start),
        .continuous  (continuous),
        .stop        (stop),
        .adc_convst  (adc_convst),
        .adc_result  (adc_result),
        .chan        (chan),
        .busy        (busy),
        .scan_done   (scan_done),
        .ch_valid    (ch_valid),
        .rd_chan     (rd_chan),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (scan_done === 1'b1) sd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_bank(input int ch, input string tag);
        rd_chan = 3'(ch);
        #1;
        check($sformatf("%s_bank%0d", tag, ch), 32'(rd_data), 32'(m_bank[ch]));
    endtask

    task automatic push_pass(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) exp_q.push_back(3'(i));
        end
    endtask

    task automatic do_start(input logic [7:0] m, input logic c);
        @(negedge clk);
        enable_mask = m;
        continuous  = c;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One ADC frame: rising CONVST, model's pipelined result, config capture from chan.
    task automatic frame(input bit iss, input bit stp);
        logic [2:0]  cur;
        logic [2:0]  exp_ch;
        logic [11:0] smp;
        @(negedge clk);
        adc_convst = 1'b1;
        stop       = stp;
        adc_result = res2;
        if (iss2) m_bank[cfg2] = res2;
        cur = chan;
        if (iss) begin
            exp_ch = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
            check("issue_ch", 32'(cur), 32'(exp_ch));
        end
        smp  = rnd ? 12'($urandom) : (12'h1A0 + {9'd0, cur});
        cfg2 = cfg1; res2 = res1; iss2 = iss1;
        cfg1 = cur;  res1 = smp;  iss1 = iss;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        adc_convst = 1'b0;
        repeat (FL - 4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; enable_mask = '0; start = 1'b0; continuous = 1'b0; stop = 1'b0;
        adc_convst = 1'b0; adc_result = '0; rd_chan = '0;
        cfg1 = '0; cfg2 = '0; res1 = '0; res2 = '0; iss1 = 1'b0; iss2 = 1'b0; rnd = 1'b0;
        for (int i = 0; i < 8; i++) m_bank[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values
        check("rst_chan", 32'(chan), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_scan_done", 32'(scan_done), 0);
        check("rst_ch_valid", 32'(ch_valid), 0);
        for (int i = 0; i < 8; i++) chk_bank(i, "rst");

        // Start with an empty mask is ignored
        do_start(8'h00, 1'b0);
        check("m0_busy_now", 32'(busy), 0);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check("m0_busy", 32'(busy), 0);
        check("m0_chan", 32'(chan), 0);
        check("m0_ch_valid", 32'(ch_valid), 0);
        chk_bank(0, "m0");

        // Single pass over channels 0 and 2
        sd0 = sd_cnt;
        do_start(8'h05, 1'b0);
        push_pass(8'h05);
        check("ss_busy_rise", 32'(busy), 1);
        frame(1'b1, 1'b0);
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        check("ss_busy_f3", 32'(busy), 1);
        frame(1'b0, 1'b0);
        check("ss_busy_f4", 32'(busy), 0);
        check("ss_ch_valid", 32'(ch_valid), 32'h05);
        check("ss_scan_done", sd_cnt - sd0, 1);
        check("ss_exp_left", exp_q.size(), 0);
        chk_bank(0, "ss");
        chk_bank(1, "ss");
        chk_bank(2, "ss");
        check("ss_bank2_lit", 32'(m_bank[2]), 32'h1A2);

        // Continuous full mask, random samples, stop coincident with an edge in pass 3
        rnd = 1'b1;
        sd0 = sd_cnt;
        do_start(8'hFF, 1'b1);
        push_pass(8'hFF); push_pass(8'hFF); push_pass(8'hFF);
        for (int f = 1; f <= 24; f++) frame(1'b1, f == 20);
        check("ct_busy_pre_drain", 32'(busy), 1);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check("ct_busy", 32'(busy), 0);
        check("ct_scan_done", sd_cnt - sd0, 3);
        check("ct_ch_valid", 32'(ch_valid), 32'hFF);
        check("ct_exp_left", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) chk_bank(i, "ct");
        rnd = 1'b0;

        // Reset mid-frame with the pipeline full
        do_start(8'h0F, 1'b1);
        push_pass(8'h0F);
        frame(1'b1, 1'b0);
        frame(1'b1, 1'b0);
        frame(1'b1, 1'b0);
        @(negedge clk);
        adc_convst = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) m_bank[i] = '0;
        iss1 = 1'b0; iss2 = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mr_chan", 32'(chan), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_scan_done", 32'(scan_done), 0);
        check("mr_ch_valid", 32'(ch_valid), 0);
        chk_bank(0, "mr");
        chk_bank(1, "mr");
        adc_convst = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_start(8'h80, 1'b0);
        push_pass(8'h80);
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        chk_bank(7, "mr_f2");
        frame(1'b0, 1'b0);
        chk_bank(7, "mr_f3");
        check("mr_bank7_lit", 32'(m_bank[7]), 32'h1A7);
        check("mr_ch_valid_after", 32'(ch_valid), 32'h80);
        check("mr_busy_after", 32'(busy), 0);

        // Mask change 03 -> 30 during continuous pass 1
        sd0 = sd_cnt;
        do_start(8'h03, 1'b1);
        exp_q.push_back(3'd0); exp_q.push_back(3'd1);
        exp_q.push_back(3'd4); exp_q.push_back(3'd5);
        frame(1'b1, 1'b0);
        enable_mask = 8'h30;
        frame(1'b1, 1'b0);
        frame(1'b1, 1'b0);
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        check("mc_busy", 32'(busy), 0);
        check("mc_scan_done", sd_cnt - sd0, 2);
        check("mc_ch_valid", 32'(ch_valid), 32'h33);
        check("mc_exp_left", exp_q.size(), 0);
        chk_bank(0, "mc");
        chk_bank(1, "mc");
        chk_bank(4, "mc");
        chk_bank(5, "mc");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Channel scan controller for the LTC2308 serial ADC interface. Drives the interface's 3-bit channel select, and tracks the two-frame LTC2308 pipeline (a frame's config word selects the channel whose data is returned in the next frame). It writes each returned 12-bit sample into a per-channel result bank. Supports single-shot and continuous scans over an enable mask, so downstream logic reads stable per-channel samples instead of tracking the pipeline.

## Interface
Parameters:
- NCH, 8: number of ADC channels (chan width = $clog2(NCH) = 3)
- DW, 12: sample width

Ports:
- clk  in  1  system clock, same clock as the ADC interface
- reset  in  1  asynchronous, active-high reset
- enable_mask  in  NCH  channels included in a scan; bit i = channel i
- start  in  1  one-cycle pulse; begins a scan when idle
- continuous  in  1  1 = rescan forever, 0 = single pass; sampled with start
- stop  in  1  one-cycle pulse; ends a continuous scan after the current pass in flight drains
- adc_convst  in  1  ADC_CONVST from the ADC interface; a rising edge marks a frame start
- adc_result  in  DW  result register of the ADC interface
- chan  out  3  channel select to the ADC interface
- busy  out  1  high from accepted start until the drain completes
- scan_done  out  1  one-cycle pulse when the highest enabled channel's sample is written
- ch_valid  out  NCH  bit i set once channel i has a sample since the last start
- rd_chan  in  3  bank read address
- rd_data  out  DW  combinational read of bank[rd_chan]

## Operation
- Frame edge: `convst_q` is registered on clk. `edge = adc_convst & ~convst_q`. All pipeline actions occur in the cycle `edge` is high.
- Pipeline tags: tag0 holds {v, ch} for the channel configured in the current frame. tag1 holds the same for the previous frame.
- On each `edge`:
  - if tag1.v, write bank[tag1.ch] <= adc_result and set ch_valid[tag1.ch];
  - shift tag1 <= tag0;
  - load tag0 <= {issuing, chan};
  - in the following cycle, chan <= next enabled channel.
- Next-channel rule: the lowest enabled channel strictly greater than the current one. If none exists, the pass ends. In continuous mode the rule wraps to the lowest enabled channel, and the mask is re-sampled at the wrap.
- States:
  - IDLE: on start with a nonzero mask, latch mask and continuous, clear ch_valid, set chan = lowest enabled channel, go to SCAN. A start with a zero mask is ignored.
  - SCAN: issuing = 1. After the last channel of a single pass is issued, or after a stop has been seen and the pass-end channel is issued, go to DRAIN.
  - DRAIN: issuing = 0. Wait until tag0.v = tag1.v = 0, which takes at most 2 edges, then go to IDLE.
- scan_done pulses on the write of the mask's highest channel, once per pass in both modes.
- stop is latched as a flag; it is ignored when idle.
- start while busy is ignored.
- A single-channel mask issues that channel repeatedly in continuous mode.

## Timing
- Reset values: chan = 0, busy = 0, scan_done = 0, ch_valid = 0, bank = 0, tags invalid, state IDLE.
- chan changes only in the cycle after `edge`, and is held for the rest of the frame.
- Latency: a sample for the channel issued at edge k is written at edge k+2, one clk after that frame's rising CONVST edge. For a mask with N channels, a single pass takes N+2 frames from the first edge after start.
- busy rises the cycle after start and falls the cycle after the final write.
- Simultaneous `edge` and stop: stop applies to the pass in progress; the channel issued at that edge still completes.
- Simultaneous `edge` and start: the first issue is at the next edge. The current edge only shifts the (invalid) tags.
- Reset mid-scan: everything returns to reset values immediately. A stale result is never written, because the tags are cleared.
- Mask changes during a pass are ignored until the wrap or the next start.

## Structure
- Package adc_pkg: NCH, DW, the state enum {IDLE, SCAN, DRAIN}, and the tag struct {logic v; logic [2:0] ch}.
- One sub-module, adc_next_chan: a combinational priority search (mask, current channel) -> {found, next, first}, reused for the initial channel and the wrap.
- The bank is an 8 x 12 register array with async read.

## Test plan
- Single-shot, mask 8'b0000_0101; ADC model returns 12'h1A0+channel for configured channels -> bank[0] = 1A0, bank[2] = 1A2, ch_valid = 05, one scan_done, busy low after 4 frames.
- Config check: capture the SDI config words in the model -> channel sequence 0, 2 only; chan stable for the whole frame.
- Continuous, mask 8'hFF, 3 passes with random samples -> every bank entry matches its model value, scan_done pulses 3 times; stop mid-pass 3 -> pass completes, drains, busy drops.
- start with mask 0 -> busy stays 0, chan stays 0, nothing written.
- Reset asserted mid-frame with tags valid -> all outputs at reset values; next start with mask 8'h80 -> bank[7] written after 3 frames.
- Mask changed from 8'h03 to 8'h30 during continuous pass 1 -> pass 1 covers channels 0 and 1, pass 2 covers channels 4 and 5.
